// File: rtl/seq_acoes_pkg.sv
// Shared types and constants for the parametrised action sequencer.
// Mode 11 behaviour depends on MODO_PROG_EN (see seq_acoes_param).
package seq_acoes_pkg;

  typedef enum logic [1:0] {
    PARADO   = 2'd0,
    CONTANDO = 2'd1,
    PAUSA    = 2'd2
  } estado_t;

  localparam logic [1:0] MODO_P2  = 2'b00;
  localparam logic [1:0] MODO_P4  = 2'b01;
  localparam logic [1:0] MODO_P8  = 2'b10;
  localparam logic [1:0] MODO_EXT = 2'b11;

  localparam int PER_2  = 2;
  localparam int PER_4  = 4;
  localparam int PER_8  = 8;
  localparam int PER_16 = 16;

  // Fixed period for each mode; mode 11 may be overridden by the programmable input.
  function automatic int per_fixo(input logic [1:0] modo);
    case (modo)
      MODO_P2: per_fixo = PER_2;
      MODO_P4: per_fixo = PER_4;
      MODO_P8: per_fixo = PER_8;
      default: per_fixo = PER_16;
    endcase
  endfunction

endpackage

// File: rtl/contador_periodo.sv
// Period counter with a latched period, stored as period-1 so a period
// of 2**CNT_W still fits. terminal is high when the count reaches period-1.
module contador_periodo
  import seq_acoes_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             inc,
  input  logic             clear,
  input  logic [CNT_W-1:0] per_m1_in,
  output logic [CNT_W-1:0] cnt,
  output logic             terminal
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] per_m1_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg    <= '0;
      per_m1_reg <= CNT_W'(PER_2 - 1);
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg    <= '0;
      per_m1_reg <= per_m1_in;
    end else if (inc) begin
      // The next period is only picked up at the boundary, never mid-period.
      if (terminal) begin
        cnt_reg    <= '0;
        per_m1_reg <= per_m1_in;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign terminal = (cnt_reg == per_m1_reg);
  assign cnt      = cnt_reg;

endmodule

// File: rtl/seq_acoes_param.sv
// Action sequencer: advances acao once per selected period while enabled.
// Define MODO_PROG_EN to let chave=11 use the programmable periodo input.
module seq_acoes_param
  import seq_acoes_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int N_ACOES = 4,
  localparam int AW     = $clog2(N_ACOES)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             habilita,
  input  logic             limpar,
  input  logic [1:0]       chave,
  input  logic [CNT_W-1:0] periodo,
  output logic [AW-1:0]    acao,
  output logic             troca,
  output logic [CNT_W-1:0] contagem,
  output logic             ocupado
);

  estado_t          estado_reg;
  logic [AW-1:0]    acao_reg;
  logic             troca_reg;
  logic             ocupado_reg;
  logic [CNT_W-1:0] per_sel_m1;
  logic             terminal;
  logic             cnt_load;
  logic             cnt_inc;
  logic [AW-1:0]    acao_next;

  always_comb begin
    per_sel_m1 = CNT_W'(per_fixo(chave) - 1);
`ifdef MODO_PROG_EN
    // 0 and 1 both mean a one-cycle period.
    if (chave == MODO_EXT)
      per_sel_m1 = (periodo > CNT_W'(1)) ? (periodo - CNT_W'(1)) : '0;
`endif
  end

`ifndef MODO_PROG_EN
  logic unused_periodo;
  assign unused_periodo = ^periodo;
`endif

  // PAUSA with habilita high counts that cycle, so only low cycles stall the period.
  assign cnt_load = (estado_reg == PARADO) && habilita && !limpar;
  assign cnt_inc  = (estado_reg != PARADO) && habilita && !limpar;

  contador_periodo #(
    .CNT_W(CNT_W)
  ) u_contador (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (cnt_load),
    .inc       (cnt_inc),
    .clear     (limpar),
    .per_m1_in (per_sel_m1),
    .cnt       (contagem),
    .terminal  (terminal)
  );

  assign acao_next = (acao_reg == AW'(N_ACOES - 1)) ? '0 : acao_reg + AW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado_reg  <= PARADO;
      acao_reg    <= '0;
      troca_reg   <= 1'b0;
      ocupado_reg <= 1'b0;
    end else if (limpar) begin
      estado_reg  <= PARADO;
      acao_reg    <= '0;
      troca_reg   <= 1'b0;
      ocupado_reg <= 1'b0;
    end else begin
      case (estado_reg)
        PARADO: begin
          troca_reg <= 1'b0;
          if (habilita) begin
            estado_reg  <= CONTANDO;
            ocupado_reg <= 1'b1;
          end
        end
        CONTANDO, PAUSA: begin
          ocupado_reg <= 1'b1;
          if (habilita) begin
            estado_reg <= CONTANDO;
            if (terminal) begin
              acao_reg  <= acao_next;
              troca_reg <= 1'b1;
            end else begin
              troca_reg <= 1'b0;
            end
          end else begin
            estado_reg <= PAUSA;
            troca_reg  <= 1'b0;
          end
        end
        default: begin
          estado_reg  <= PARADO;
          acao_reg    <= '0;
          troca_reg   <= 1'b0;
          ocupado_reg <= 1'b0;
        end
      endcase
    end
  end

  assign acao  = acao_reg;
  assign troca = troca_reg;
  assign ocupado = ocupado_reg;

endmodule

// File: tb/tb_seq_acoes_param.sv
// Self-checking bench for seq_acoes_param: a 4-action and a 3-action instance
// share all stimulus and are compared every cycle against a behavioural model.
module tb_seq_acoes_param;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             habilita = 1'b0;
  logic             limpar = 1'b0;
  logic [1:0]       chave = 2'b00;
  logic [CNT_W-1:0] periodo = '0;

  logic [1:0]       acao4, acao3;
  logic             troca4, troca3;
  logic [CNT_W-1:0] cont4, cont3;
  logic             ocup4, ocup3;

  seq_acoes_param #(.CNT_W(CNT_W), .N_ACOES(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .habilita(habilita), .limpar(limpar),
    .chave(chave), .periodo(periodo), .acao(acao4), .troca(troca4),
    .contagem(cont4), .ocupado(ocup4)
  );

  seq_acoes_param #(.CNT_W(CNT_W), .N_ACOES(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .habilita(habilita), .limpar(limpar),
    .chave(chave), .periodo(periodo), .acao(acao3), .troca(troca3),
    .contagem(cont3), .ocupado(ocup3)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int a4;
    int a3;
    int troca;
    int cnt;
    int ocup;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    string      nome;
    logic [1:0] ch;
    int         per;
    logic       hab;
    logic       lim;
    int         ciclos;
    int         exp_trocas;
    int         exp_cnt;   // -1: not checked
    int         exp_a4;    // -1: not checked
  } seg_t;
  seg_t tab[$];

  // Behavioural reference written from the operating rules.
  int m_st, m_cnt, m_per, m_a4, m_a3, m_troca;

  function automatic int per_of(input logic [1:0] ch, input int p);
    case (ch)
      2'b00: return 2;
      2'b01: return 4;
      2'b10: return 8;
      default: begin
`ifdef MODO_PROG_EN
        return (p < 2) ? 1 : p;
`else
        return 16;
`endif
      end
    endcase
  endfunction

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_per = 2; m_a4 = 0; m_a3 = 0; m_troca = 0;
  endtask

  task automatic model_step(input logic h, input logic l, input logic [1:0] ch, input int p);
    if (l) begin
      m_st = 0; m_cnt = 0; m_a4 = 0; m_a3 = 0; m_troca = 0;
    end else if (m_st == 0) begin
      m_troca = 0;
      if (h) begin
        m_st = 1; m_cnt = 0; m_per = per_of(ch, p);
      end
    end else if (h) begin
      m_st = 1;
      if (m_cnt == m_per - 1) begin
        m_cnt = 0;
        m_a4 = (m_a4 + 1) % 4;
        m_a3 = (m_a3 + 1) % 3;
        m_troca = 1;
        m_per = per_of(ch, p);
      end else begin
        m_cnt = m_cnt + 1;
        m_troca = 0;
      end
    end else begin
      m_st = 2; m_troca = 0;
    end
  endtask

  task automatic chk(input string nome, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nome, act, expv, $time);
    end
  endtask

  // One clock cycle: drive, predict, wait for the edge, compare.
  task automatic cyc(input logic h, input logic l, input logic [1:0] ch, input int p,
                     output int tr);
    exp_t e;
    habilita = h; limpar = l; chave = ch; periodo = CNT_W'(p);
    model_step(h, l, ch, p);
    e.a4 = m_a4; e.a3 = m_a3; e.troca = m_troca; e.cnt = m_cnt; e.ocup = (m_st != 0) ? 1 : 0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("acao4",    int'(acao4),  e.a4);
    chk("acao3",    int'(acao3),  e.a3);
    chk("troca4",   int'(troca4), e.troca);
    chk("troca3",   int'(troca3), e.troca);
    chk("contagem4", int'(cont4), e.cnt);
    chk("contagem3", int'(cont3), e.cnt);
    chk("ocupado4", int'(ocup4),  e.ocup);
    chk("ocupado3", int'(ocup3),  e.ocup);
    tr = int'(troca4);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_acao4"},    int'(acao4),  0);
    chk({tag, "_acao3"},    int'(acao3),  0);
    chk({tag, "_troca4"},   int'(troca4), 0);
    chk({tag, "_contagem"}, int'(cont4),  0);
    chk({tag, "_ocupado"},  int'(ocup4),  0);
    chk({tag, "_ocupado3"}, int'(ocup3),  0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int tr, soma;
`ifdef MODO_PROG_EN
    localparam bit PROG = 1'b1;
`else
    localparam bit PROG = 1'b0;
`endif
    tab.push_back('{"limpa0",      2'b00, 0, 1'b0, 1'b1, 1,  0, 0, 0});
    tab.push_back('{"p2_corre",    2'b00, 0, 1'b1, 1'b0, 9,  4, 0, 0});
    tab.push_back('{"limpa1",      2'b00, 0, 1'b0, 1'b1, 1,  0, 0, 0});
    tab.push_back('{"p8_ate3",     2'b10, 0, 1'b1, 1'b0, 4,  0, 3, 0});
    tab.push_back('{"p8_pausa",    2'b10, 0, 1'b0, 1'b0, 5,  0, 3, 0});
    tab.push_back('{"p8_retoma",   2'b10, 0, 1'b1, 1'b0, 5,  1, 0, 1});
    tab.push_back('{"limpa2",      2'b10, 0, 1'b0, 1'b1, 1,  0, 0, 0});
    tab.push_back('{"p2_cnt1",     2'b00, 0, 1'b1, 1'b0, 2,  0, 1, 0});
    tab.push_back('{"troca_ch01",  2'b01, 0, 1'b1, 1'b0, 1,  1, 0, 1});
    tab.push_back('{"p4_corre",    2'b01, 0, 1'b1, 1'b0, 4,  1, 0, 2});
    tab.push_back('{"p4_ate3",     2'b01, 0, 1'b1, 1'b0, 3,  0, 3, 2});
    tab.push_back('{"limpar_term", 2'b01, 0, 1'b1, 1'b1, 1,  0, 0, 0});
    tab.push_back('{"m11_per5",    2'b11, 5, 1'b1, 1'b0, 11, PROG ? 2 : 0,  PROG ? 0 : 10, -1});
    tab.push_back('{"limpa3",      2'b11, 5, 1'b0, 1'b1, 1,  0, 0, 0});
    tab.push_back('{"m11_per0",    2'b11, 0, 1'b1, 1'b0, 4,  PROG ? 3 : 0,  PROG ? 0 : 3, -1});
    tab.push_back('{"limpa4",      2'b11, 0, 1'b0, 1'b1, 1,  0, 0, 0});
    tab.push_back('{"m11_longo",   2'b11, 0, 1'b1, 1'b0, 17, PROG ? 16 : 1, 0, -1});
    tab.push_back('{"limpa5",      2'b11, 0, 1'b0, 1'b1, 1,  0, 0, 0});

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset_inicial");
    #3 reset_n = 1'b1;

    foreach (tab[i]) begin
      soma = 0;
      for (int c = 0; c < tab[i].ciclos; c++) begin
        cyc(tab[i].hab, tab[i].lim, tab[i].ch, tab[i].per, tr);
        soma += tr;
      end
      chk({tab[i].nome, "_trocas"}, soma, tab[i].exp_trocas);
      if (tab[i].exp_cnt >= 0) chk({tab[i].nome, "_cnt_fim"}, int'(cont4), tab[i].exp_cnt);
      if (tab[i].exp_a4 >= 0)  chk({tab[i].nome, "_acao_fim"}, int'(acao4), tab[i].exp_a4);
      $display("seg %-12s chave=%b hab=%0b lim=%0b ciclos=%0d trocas=%0d acao4=%0d contagem=%0d",
               tab[i].nome, tab[i].ch, tab[i].hab, tab[i].lim, tab[i].ciclos, soma,
               acao4, cont4);
    end

    // Asynchronous reset mid-period on the 3-action instance with acao=2.
    soma = 0;
    for (int c = 0; c < 6; c++) begin
      cyc(1'b1, 1'b0, 2'b00, 0, tr);
      soma += tr;
    end
    chk("pre_reset_acao3", int'(acao3), 2);
    chk("pre_reset_cnt", int'(cont3), 1);
    #1 reset_n = 1'b0;
    #2;
    chk_reset_vals("reset_meio");
    model_reset();
    #1 reset_n = 1'b1;
    $display("txn reset_meio: saidas apos reset acao3=%0d troca=%0d contagem=%0d ocupado=%0d",
             acao3, troca3, cont3, ocup3);

    soma = 0;
    for (int c = 0; c < 7; c++) begin
      cyc(1'b1, 1'b0, 2'b00, 0, tr);
      soma += tr;
    end
    chk("reinicio_trocas", soma, 3);
    chk("reinicio_acao3_wrap", int'(acao3), 0);
    chk("reinicio_acao4", int'(acao4), 3);
    $display("txn reinicio: trocas=%0d acao3=%0d acao4=%0d", soma, acao3, acao4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
